// File: rtl/vga_pkg.sv
// vga_pkg: shared pattern enum, default 640x480@60 timing and ui_in field positions
package vga_pkg;
    typedef enum logic [1:0] {PAT_HRAMP, PAT_VRAMP, PAT_XOR, PAT_BARS} pattern_e;
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam int CNT_W        = 12;
    localparam int UI_PAT_LO    = 0;
    localparam int UI_PAT_HI    = 1;
    localparam int UI_INV       = 2;
    localparam int UI_ANIM      = 3;
    localparam int MODE_W       = 4;
endpackage

// File: rtl/vga_timing.sv
// vga_timing: h/v raster counters with combinational sync/blank decode and end-of-frame strobe
module vga_timing import vga_pkg::*; #(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [CNT_W-1:0] h,
    output logic [CNT_W-1:0] v,
    output logic             h_blank,
    output logic             v_blank,
    output logic             h_sync_on,
    output logic             v_sync_on,
    output logic             eof
);
    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [CNT_W-1:0] H_SS   = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] H_SE   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] V_SS   = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] V_SE   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic h_end, v_end;

    assign h_end     = h == H_LAST;
    assign v_end     = v == V_LAST;
    assign eof       = h_end & v_end;
    assign h_blank   = h >= CNT_W'(H_ACTIVE);
    assign v_blank   = v >= CNT_W'(V_ACTIVE);
    assign h_sync_on = (h >= H_SS) && (h < H_SE);
    assign v_sync_on = (v >= V_SS) && (v < V_SE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h <= '0;
            v <= '0;
        end else begin
            h <= h_end ? '0 : h + 1'b1;
            if (h_end) v <= v_end ? '0 : v + 1'b1;
        end
    end
endmodule

// File: rtl/vga_ramp_gen.sv
// vga_ramp_gen: VGA test-pattern generator with registered sync/blank and true/complement colour outputs.
// Define VGA_RAMP_DEBUG_EN to expose o_mode, o_frame and o_visible.
module vga_ramp_gen import vga_pkg::*; #(
    parameter int COLOR_BITS = 8,
    parameter int H_ACTIVE   = DEF_H_ACTIVE,
    parameter int H_FP       = DEF_H_FP,
    parameter int H_SYNC     = DEF_H_SYNC,
    parameter int H_BP       = DEF_H_BP,
    parameter int V_ACTIVE   = DEF_V_ACTIVE,
    parameter int V_FP       = DEF_V_FP,
    parameter int V_SYNC     = DEF_V_SYNC,
    parameter int V_BP       = DEF_V_BP,
    parameter int SYNC_NEG   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            ui_in,
    output logic                  hsync,
    output logic                  vsync,
    output logic                  hblank,
    output logic                  vblank,
    output logic [COLOR_BITS-1:0] r,
    output logic [COLOR_BITS-1:0] g,
    output logic [COLOR_BITS-1:0] b,
    output logic [COLOR_BITS-1:0] rn,
    output logic [COLOR_BITS-1:0] gn,
    output logic [COLOR_BITS-1:0] bn
`ifdef VGA_RAMP_DEBUG_EN
    ,
    output logic [7:0]            o_mode,
    output logic [7:0]            o_frame,
    output logic                  o_visible
`endif
);
    localparam int   C  = COLOR_BITS;
    localparam int   BW = H_ACTIVE / 8;
    localparam logic SP = SYNC_NEG != 0;

    logic [CNT_W-1:0] h, v;
    logic             hb_c, vb_c, hs_on, vs_on, eof, active;
    logic [MODE_W-1:0] mode;
    logic [7:0]       frame;
    pattern_e         pat;
    logic [2:0]       bar;
    logic [C-1:0]     a, hc, vc, hr, vr, xr, inv, r_c, g_c, b_c, r_o, g_o, b_o;
    logic             unused_bits;

    vga_timing #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) u_timing (
        .clk(clk), .rst_n(rst_n), .h(h), .v(v), .h_blank(hb_c), .v_blank(vb_c),
        .h_sync_on(hs_on), .v_sync_on(vs_on), .eof(eof)
    );

    assign unused_bits = &{1'b0, ui_in[7:MODE_W], v[CNT_W-1:C]};

    // Bar index from threshold compares; the highest threshold reached wins.
    always_comb begin
        bar = '0;
        for (int k = 1; k < 8; k++)
            if (h >= CNT_W'(k * BW)) bar = 3'(k);
    end

    assign pat    = pattern_e'(mode[UI_PAT_HI:UI_PAT_LO]);
    assign a      = mode[UI_ANIM] ? frame[C-1:0] : '0;
    assign hc     = h[C-1:0];
    assign vc     = v[C-1:0];
    assign hr     = hc + a;
    assign vr     = vc + a;
    assign xr     = (hc ^ vc) + a;
    assign inv    = {C{mode[UI_INV]}};
    assign active = !(hb_c || vb_c);

    always_comb begin
        r_c = pat == PAT_HRAMP ? hr : pat == PAT_VRAMP ? vr : pat == PAT_XOR ? xr : {C{bar[0]}};
        g_c = pat == PAT_HRAMP ? hr : pat == PAT_VRAMP ? vr : pat == PAT_XOR ? hc : {C{bar[1]}};
        b_c = pat == PAT_HRAMP ? hr : pat == PAT_VRAMP ? vr : pat == PAT_XOR ? vc : {C{bar[2]}};
        r_o = active ? r_c ^ inv : '0;
        g_o = active ? g_c ^ inv : '0;
        b_o = active ? b_c ^ inv : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync  <= SP;
            vsync  <= SP;
            hblank <= 1'b1;
            vblank <= 1'b1;
            r      <= '0;
            g      <= '0;
            b      <= '0;
            rn     <= '1;
            gn     <= '1;
            bn     <= '1;
            mode   <= '0;
            frame  <= '0;
        end else begin
            hsync  <= hs_on ^ SP;
            vsync  <= vs_on ^ SP;
            hblank <= hb_c;
            vblank <= vb_c;
            r      <= r_o;
            g      <= g_o;
            b      <= b_o;
            rn     <= ~r_o;
            gn     <= ~g_o;
            bn     <= ~b_o;
            // Capture on the last pixel so a frame never mixes modes.
            if (eof) begin
                mode  <= ui_in[MODE_W-1:0];
                frame <= frame + 1'b1;
            end
        end
    end

`ifdef VGA_RAMP_DEBUG_EN
    assign o_mode    = {4'b0, mode};
    assign o_frame   = frame;
    assign o_visible = ~(hblank | vblank);
`endif
endmodule

// File: tb/tb_vga_ramp_gen.sv
// tb_vga_ramp_gen: scoreboard bench on a reduced 48x14 raster (32x8 visible, 4-bit colour)
module tb_vga_ramp_gen;
    logic       clk = 0, rst_n = 0;
    logic [7:0] ui_in = 8'h00;
    logic       hsync, vsync, hblank, vblank;
    logic [3:0] r, g, b, rn, gn, bn;
    int         cyc = 0, n_chk = 0, n_fail = 0;
    bit         counting = 1;
    int         hs_cnt = 0, hb_cnt = 0, vs_cnt = 0;

    typedef struct {
        int         cyc;
        string      tag;
        logic [3:0] fl;
        logic [3:0] r, g, b;
    } exp_t;
    exp_t q[$];

    vga_ramp_gen #(
        .COLOR_BITS(4), .H_ACTIVE(32), .H_FP(4), .H_SYNC(8), .H_BP(4),
        .V_ACTIVE(8), .V_FP(2), .V_SYNC(2), .V_BP(2), .SYNC_NEG(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ui_in(ui_in), .hsync(hsync), .vsync(vsync),
        .hblank(hblank), .vblank(vblank), .r(r), .g(g), .b(b), .rn(rn), .gn(gn), .bn(bn)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n)
        if (!rst_n) cyc <= 0;
        else cyc <= cyc + 1;

    // fl = {hsync, vsync, hblank, vblank}
    task automatic expect_px(input int c, input string t, input logic [3:0] fl,
                             input logic [3:0] er, input logic [3:0] eg, input logic [3:0] eb);
        exp_t e;
        e.cyc = c; e.tag = t; e.fl = fl; e.r = er; e.g = eg; e.b = eb;
        q.push_back(e);
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic check_count(input string t, input int got, input int want);
        n_chk++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", t, got, want);
        end
    endtask

    // Monitor: outputs are sampled mid-cycle; the head entry is compared when its cycle arrives.
    initial forever begin
        @(negedge clk);
        #1;
        if (counting) begin
            if (cyc >= 1 && cyc <= 48) begin
                hs_cnt += int'(!hsync);
                hb_cnt += int'(hblank);
            end
            if (cyc >= 1 && cyc <= 672) vs_cnt += int'(!vsync);
            if (cyc == 48) begin
                check_count("hsync_width", hs_cnt, 8);
                check_count("hblank_width", hb_cnt, 16);
            end
            if (cyc == 672) check_count("vsync_width", vs_cnt, 96);
        end
        while (q.size() > 0 && q[0].cyc == cyc) begin
            logic [27:0] got, want;
            exp_t e;
            e = q.pop_front();
            got  = {hsync, vsync, hblank, vblank, r, g, b, rn, gn, bn};
            want = {e.fl, e.r, e.g, e.b, ~e.r, ~e.g, ~e.b};
            n_chk++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL %s @cyc %0d: got %h expected %h", e.tag, cyc, got, want);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        expect_px(0, "reset", 4'b1111, 0, 0, 0);
        repeat (5) @(negedge clk);
        expect_px(1,   "p00",       4'b1100, 0, 0, 0);
        expect_px(16,  "h15",       4'b1100, 15, 15, 15);
        expect_px(17,  "h16_wrap",  4'b1100, 0, 0, 0);
        expect_px(32,  "h31",       4'b1100, 15, 15, 15);
        expect_px(33,  "hblank",    4'b1110, 0, 0, 0);
        expect_px(36,  "pre_hs",    4'b1110, 0, 0, 0);
        expect_px(37,  "hs_start",  4'b0110, 0, 0, 0);
        expect_px(44,  "hs_last",   4'b0110, 0, 0, 0);
        expect_px(45,  "hs_off",    4'b1110, 0, 0, 0);
        expect_px(54,  "l1_h5",     4'b1100, 5, 5, 5);
        expect_px(150, "mid_ign",   4'b1100, 5, 5, 5);
        expect_px(385, "vblank",    4'b1101, 0, 0, 0);
        expect_px(480, "pre_vs",    4'b1111, 0, 0, 0);
        expect_px(481, "vs_start",  4'b1001, 0, 0, 0);
        expect_px(576, "vs_last",   4'b1011, 0, 0, 0);
        expect_px(577, "vs_off",    4'b1101, 0, 0, 0);
        rst_n = 1;
        wait_cyc(100);
        ui_in = 8'h03;
        expect_px(673, "bar0",      4'b1100, 0, 0, 0);
        expect_px(677, "bar1",      4'b1100, 15, 0, 0);
        expect_px(680, "bar1_end",  4'b1100, 15, 0, 0);
        expect_px(681, "bar2",      4'b1100, 0, 15, 0);
        expect_px(685, "bar3",      4'b1100, 15, 15, 0);
        expect_px(693, "bar5",      4'b1100, 15, 0, 15);
        expect_px(701, "bar7",      4'b1100, 15, 15, 15);
        expect_px(705, "bar_blank", 4'b1110, 0, 0, 0);
        wait_cyc(800);
        ui_in = 8'h04;
        expect_px(1345, "inv00",     4'b1100, 15, 15, 15);
        expect_px(1350, "inv_h5",    4'b1100, 10, 10, 10);
        expect_px(1377, "inv_blank", 4'b1110, 0, 0, 0);
        wait_cyc(1400);
        ui_in = 8'h08;
        expect_px(2017, "anim00",    4'b1100, 3, 3, 3);
        expect_px(2022, "anim_h5",   4'b1100, 8, 8, 8);
        expect_px(2030, "anim_wrap", 4'b1100, 0, 0, 0);
        wait_cyc(2100);
        ui_in = 8'h09;
        expect_px(2785, "vramp_anim", 4'b1100, 6, 6, 6);
        wait_cyc(2800);
        ui_in = 8'h02;
        expect_px(3510, "xor_5_3",  4'b1100, 6, 5, 3);
        expect_px(3661, "xor_12_6", 4'b1100, 10, 12, 6);
        wait_cyc(3670);
        counting = 0;
        ui_in = 8'h08;
        expect_px(0, "rst_mid", 4'b1111, 0, 0, 0);
        rst_n = 0;
        repeat (3) @(negedge clk);
        expect_px(1,   "post_rst00", 4'b1100, 0, 0, 0);
        expect_px(6,   "post_rst_h5", 4'b1100, 5, 5, 5);
        expect_px(673, "frame1_00",  4'b1100, 1, 1, 1);
        expect_px(678, "frame1_h5",  4'b1100, 6, 6, 6);
        rst_n = 1;
        wait_cyc(700);
        check_count("queue_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
